// File: rtl/snd_spi_tx.sv
// SPI mode-0 master transmitter: one byte per SSEL frame, MSB first, SCK = ACLK / (2*CLKDIV).
// Optional SND_SPI_TX_BURST_EN chains bytes inside one SSEL-low frame.
module snd_spi_tx #(
  parameter int CLKDIV   = 8,
  parameter int IDLE_CYC = 16
) (
  input  logic       ACLK,
  input  logic       ARST,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic       TX_BUSY,
  output logic       TX_DONE,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLKDIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(IDLE_CYC - 1);

  state_t     state_reg;
  logic [7:0] div_cnt_reg;
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt_reg;
  logic       sck_reg;
  logic       ssel_reg;
  logic       mosi_reg;
  logic       done_reg;
  logic       last_fall;
  logic       handshake;

  // Cycle whose closing edge produces the 8th SCK falling edge of the byte.
  assign last_fall = (state_reg == SHIFT) && sck_reg &&
                     (div_cnt_reg == 8'd0) && (bit_cnt_reg == 3'd7);

  always_comb begin
    TX_READY = 1'b0;
    if (!ARST) begin
`ifdef SND_SPI_TX_BURST_EN
      TX_READY = (state_reg == IDLE) || last_fall;
`else
      TX_READY = (state_reg == IDLE);
`endif
    end
  end

  assign handshake = TX_VALID & TX_READY;

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      state_reg   <= IDLE;
      div_cnt_reg <= 8'd0;
      shift_reg   <= 7'd0;
      bit_cnt_reg <= 3'd0;
      sck_reg     <= 1'b0;
      ssel_reg    <= 1'b1;
      mosi_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            shift_reg   <= TX_DATA[6:0];
            mosi_reg    <= TX_DATA[7];
            ssel_reg    <= 1'b0;
            bit_cnt_reg <= 3'd0;
            div_cnt_reg <= DIV_LOAD;
            state_reg   <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt_reg == 8'd0) begin
            sck_reg     <= 1'b1;
            div_cnt_reg <= DIV_LOAD;
            state_reg   <= SHIFT;
          end else begin
            div_cnt_reg <= div_cnt_reg - 8'd1;
          end
        end
        SHIFT: begin
          if (div_cnt_reg != 8'd0) begin
            div_cnt_reg <= div_cnt_reg - 8'd1;
          end else begin
            div_cnt_reg <= DIV_LOAD;
            sck_reg     <= ~sck_reg;
            if (last_fall) begin
              // MOSI keeps the LSB through the hold phase.
`ifdef SND_SPI_TX_BURST_EN
              if (handshake) begin
                shift_reg   <= TX_DATA[6:0];
                mosi_reg    <= TX_DATA[7];
                bit_cnt_reg <= 3'd0;
                done_reg    <= 1'b1;
                state_reg   <= SETUP;
              end else begin
                state_reg <= HOLD;
              end
`else
              state_reg <= HOLD;
`endif
            end else if (sck_reg) begin
              shift_reg   <= {shift_reg[5:0], 1'b0};
              mosi_reg    <= shift_reg[6];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end
        end
        HOLD: begin
          if (div_cnt_reg == 8'd0) begin
            ssel_reg    <= 1'b1;
            done_reg    <= 1'b1;
            div_cnt_reg <= GAP_LOAD;
            state_reg   <= GAP;
          end else begin
            div_cnt_reg <= div_cnt_reg - 8'd1;
          end
        end
        GAP: begin
          if (div_cnt_reg == 8'd0) begin
            state_reg <= IDLE;
          end else begin
            div_cnt_reg <= div_cnt_reg - 8'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign TX_BUSY = (state_reg != IDLE);
  assign TX_DONE = done_reg;
  assign SCK     = sck_reg;
  assign SSEL    = ssel_reg;
  assign MOSI    = mosi_reg;

endmodule

// File: tb/tb_snd_spi_tx.sv
// Directed bench for snd_spi_tx (CLKDIV=4, IDLE_CYC=16) with a rising-edge sampling receiver model.
// Burst scenario is compiled only when SND_SPI_TX_BURST_EN is defined.
module tb_snd_spi_tx;

  logic       ACLK = 1'b0;
  logic       ARST = 1'b1;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic       TX_BUSY;
  logic       TX_DONE;
  logic       SCK;
  logic       SSEL;
  logic       MOSI;

  int checks = 0;
  int errors = 0;

  snd_spi_tx #(.CLKDIV(4), .IDLE_CYC(16)) dut (
    .ACLK(ACLK), .ARST(ARST), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_READY(TX_READY), .TX_BUSY(TX_BUSY), .TX_DONE(TX_DONE),
    .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI)
  );

  always #5 ACLK = ~ACLK;

  // Line monitor / receiver model, sampled mid-cycle.
  logic        sck_prev = 1'b0;
  logic        ssel_prev = 1'b1;
  int          rise_cnt = 0;
  int          done_cnt = 0;
  int          hs_cnt = 0;
  int          strobe_cnt = 0;
  int          low_run = 0;
  int          high_run = 0;
  int          last_low_len = 0;
  int          last_gap = 0;
  int          frame_bits = 0;
  logic [31:0] rx_bits = 32'd0;
  logic [7:0]  rx_frame = 8'd0;
  logic [7:0]  rx_last = 8'd0;

  always @(negedge ACLK) begin
    sck_prev  <= SCK;
    ssel_prev <= SSEL;
    if (TX_DONE === 1'b1) done_cnt <= done_cnt + 1;
    if (TX_VALID === 1'b1 && TX_READY === 1'b1) hs_cnt <= hs_cnt + 1;
    if (SSEL === 1'b0) begin
      low_run  <= low_run + 1;
      high_run <= 0;
    end else begin
      high_run <= high_run + 1;
      low_run  <= 0;
    end
    if (SSEL === 1'b1 && ssel_prev === 1'b0) begin
      last_low_len <= low_run;
      if (frame_bits == 8) begin
        strobe_cnt <= strobe_cnt + 1;
        rx_last    <= rx_frame;
      end
    end
    if (SSEL === 1'b0 && ssel_prev === 1'b1) last_gap <= high_run;
    if (SSEL !== 1'b0) begin
      frame_bits <= 0;
    end else if (SCK === 1'b1 && sck_prev === 1'b0) begin
      frame_bits <= frame_bits + 1;
      rx_frame   <= {rx_frame[6:0], MOSI};
    end
    if (SCK === 1'b1 && sck_prev === 1'b0) begin
      rise_cnt <= rise_cnt + 1;
      rx_bits  <= {rx_bits[30:0], MOSI};
    end
  end

  task automatic wait_ready(input int limit);
    int n = 0;
    while (TX_READY !== 1'b1 && n < limit) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (TX_READY !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready: TX_READY=%b after %0d cycles, required 1", TX_READY, n);
    end
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (TX_DONE !== 1'b1 && n < limit) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (TX_DONE !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_done: TX_DONE=%b after %0d cycles, required 1", TX_DONE, n);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the handshake edge.
  task automatic send_byte(input logic [7:0] d);
    TX_DATA  = d;
    TX_VALID = 1'b1;
    wait_ready(300);
    @(posedge ACLK); #1;
    TX_VALID = 1'b0;
  endtask

  task automatic test_reset;
    ARST = 1'b1;
    TX_VALID = 1'b1;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    checks++;
    if (TX_READY !== 1'b0) begin errors++; $display("FAIL reset_ready: TX_READY=%b required 0", TX_READY); end
    checks++;
    if ({SCK, SSEL, MOSI, TX_BUSY, TX_DONE} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_outputs: SCK,SSEL,MOSI,BUSY,DONE=%b required 01000", {SCK, SSEL, MOSI, TX_BUSY, TX_DONE});
    end
    TX_VALID = 1'b0;
    ARST = 1'b0;
    #1;
    checks++;
    if (TX_READY !== 1'b1) begin errors++; $display("FAIL reset_release_ready: TX_READY=%b required 1", TX_READY); end
    @(posedge ACLK); #1;
    $display("test_reset: done");
  endtask

  task automatic test_single_frame;
    int r0 = rise_cnt;
    int d0 = done_cnt;
    int s0 = strobe_cnt;
    int n = 0;
    send_byte(8'hA5);
    checks++;
    if (SSEL !== 1'b0 || TX_BUSY !== 1'b1) begin
      errors++; $display("FAIL a5_start: SSEL=%b BUSY=%b required 0 1", SSEL, TX_BUSY);
    end
    wait_done(200);
    checks++;
    if (SSEL !== 1'b1) begin errors++; $display("FAIL a5_done_with_ssel: SSEL=%b required 1", SSEL); end
    while (TX_READY !== 1'b1 && n < 100) begin
      @(posedge ACLK); #1;
      n++;
    end
    checks++;
    if (n + 1 != 17) begin errors++; $display("FAIL a5_ready_return: cycle %0d required 17", n + 1); end
    checks++;
    if (last_low_len != 68) begin errors++; $display("FAIL a5_ssel_low: %0d cycles required 68", last_low_len); end
    checks++;
    if (rise_cnt - r0 != 8) begin errors++; $display("FAIL a5_rises: %0d required 8", rise_cnt - r0); end
    checks++;
    if (rx_bits[7:0] !== 8'hA5) begin errors++; $display("FAIL a5_bits: %h required a5", rx_bits[7:0]); end
    checks++;
    if (done_cnt - d0 != 1) begin errors++; $display("FAIL a5_done_pulses: %0d required 1", done_cnt - d0); end
    checks++;
    if (strobe_cnt - s0 != 1 || SCK !== 1'b0) begin
      errors++; $display("FAIL a5_rx_strobe: strobes=%0d SCK=%b required 1 0", strobe_cnt - s0, SCK);
    end
    $display("test_single_frame: sent a5 low=%0d rises=%0d rx=%h", last_low_len, rise_cnt - r0, rx_bits[7:0]);
  endtask

  task automatic test_valid_held;
    int h0 = hs_cnt;
    int s0 = strobe_cnt;
    TX_DATA  = 8'h3C;
    TX_VALID = 1'b1;
    wait_ready(300);
    @(posedge ACLK); #1;
    repeat (20) @(posedge ACLK);
    #1;
    TX_DATA = 8'hC3;
    wait_done(200);
    @(posedge ACLK); #1;
    checks++;
    if (rx_last !== 8'h3C) begin errors++; $display("FAIL held_first_byte: %h required 3c", rx_last); end
    $display("test_valid_held: frame 1 rx=%h", rx_last);
    wait_ready(300);
    @(posedge ACLK); #1;
    TX_VALID = 1'b0;
    wait_done(200);
    @(posedge ACLK); #1;
    checks++;
    if (rx_last !== 8'hC3) begin errors++; $display("FAIL held_second_byte: %h required c3", rx_last); end
    checks++;
    if (last_gap != 17) begin errors++; $display("FAIL held_gap: %0d cycles required 17", last_gap); end
    checks++;
    if (hs_cnt - h0 != 2 || strobe_cnt - s0 != 2) begin
      errors++; $display("FAIL held_frames: handshakes=%0d strobes=%0d required 2 2", hs_cnt - h0, strobe_cnt - s0);
    end
    $display("test_valid_held: frame 2 rx=%h gap=%0d", rx_last, last_gap);
    wait_ready(100);
  endtask

  task automatic test_reset_abort;
    int r0 = rise_cnt;
    int d0;
    int s0 = strobe_cnt;
    int n = 0;
    send_byte(8'hFF);
    while (rise_cnt - r0 < 3 && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    checks++;
    if (rise_cnt - r0 != 3 || SCK !== 1'b1) begin
      errors++; $display("FAIL abort_third_rise: rises=%0d SCK=%b required 3 1", rise_cnt - r0, SCK);
    end
    d0 = done_cnt;
    ARST = 1'b1;
    #1;
    checks++;
    if (TX_READY !== 1'b0) begin errors++; $display("FAIL abort_ready: TX_READY=%b required 0", TX_READY); end
    @(posedge ACLK); #1;
    checks++;
    if ({SCK, SSEL, MOSI, TX_BUSY, TX_DONE} !== 5'b01000) begin
      errors++;
      $display("FAIL abort_outputs: SCK,SSEL,MOSI,BUSY,DONE=%b required 01000", {SCK, SSEL, MOSI, TX_BUSY, TX_DONE});
    end
    @(posedge ACLK); #1;
    ARST = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    checks++;
    if (done_cnt != d0 || strobe_cnt != s0) begin
      errors++; $display("FAIL abort_no_done: dones=%0d strobes=%0d required 0 0", done_cnt - d0, strobe_cnt - s0);
    end
    send_byte(8'h01);
    wait_done(200);
    @(posedge ACLK); #1;
    checks++;
    if (rx_last !== 8'h01 || strobe_cnt - s0 != 1) begin
      errors++; $display("FAIL abort_recover: rx=%h strobes=%0d required 01 1", rx_last, strobe_cnt - s0);
    end
    $display("test_reset_abort: recovered rx=%h", rx_last);
    wait_ready(100);
  endtask

  task automatic test_loopback;
    logic [7:0] vec [4] = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    for (int i = 0; i < 4; i++) begin
      int s0 = strobe_cnt;
      send_byte(vec[i]);
      wait_done(200);
      @(posedge ACLK); #1;
      checks++;
      if (strobe_cnt - s0 != 1 || rx_last !== vec[i]) begin
        errors++; $display("FAIL loopback_%0d: strobes=%0d rx=%h required 1 %h", i, strobe_cnt - s0, rx_last, vec[i]);
      end
      $display("test_loopback: byte %0d sent %h rx %h", i, vec[i], rx_last);
      wait_ready(100);
    end
  endtask

`ifdef SND_SPI_TX_BURST_EN
  task automatic test_back_to_back;
    int r0 = rise_cnt;
    int d0 = done_cnt;
    int n = 0;
    TX_DATA  = 8'h12;
    TX_VALID = 1'b1;
    wait_ready(300);
    @(posedge ACLK); #1;
    TX_DATA = 8'h34;
    wait_ready(300);
    @(posedge ACLK); #1;
    TX_DATA = 8'h56;
    wait_ready(300);
    @(posedge ACLK); #1;
    TX_VALID = 1'b0;
    checks++;
    if (SSEL !== 1'b0) begin errors++; $display("FAIL burst_ssel_stays_low: SSEL=%b required 0", SSEL); end
    while (SSEL !== 1'b1 && n < 300) begin
      @(posedge ACLK); #1;
      n++;
    end
    @(posedge ACLK); #1;
    checks++;
    if (last_low_len != 196) begin errors++; $display("FAIL burst_ssel_low: %0d cycles required 196", last_low_len); end
    checks++;
    if (rise_cnt - r0 != 24) begin errors++; $display("FAIL burst_rises: %0d required 24", rise_cnt - r0); end
    checks++;
    if (done_cnt - d0 != 3) begin errors++; $display("FAIL burst_dones: %0d required 3", done_cnt - d0); end
    checks++;
    if (rx_bits[23:0] !== 24'h123456) begin errors++; $display("FAIL burst_bits: %h required 123456", rx_bits[23:0]); end
    $display("test_back_to_back: low=%0d rises=%0d bits=%h", last_low_len, rise_cnt - r0, rx_bits[23:0]);
    wait_ready(100);
  endtask
`endif

  initial begin
    test_reset;
    test_single_frame;
    test_valid_held;
    test_reset_abort;
    test_loopback;
`ifdef SND_SPI_TX_BURST_EN
    test_back_to_back;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snd_spi_tx.md
Name: snd_spi_tx

Overview:
SPI-mode-0 style master transmitter that serialises parameter bytes onto SCK/SSEL/MOSI toward the sound parameter SPI receiver.
- Runs entirely in the ACLK domain and generates SCK by integer division.
- Keeps SCK phases long enough for an oversampling receiver with a multi-stage synchroniser.
- Sits between the parameter source (control FSM or register bank) and the board-level SPI pins.

Parameters:
CLKDIV, 8, SCK half-period in ACLK cycles; legal range 4..255; also the SSEL-low to first-edge setup time and the last-edge to SSEL-high hold time.
IDLE_CYC, 16, minimum SSEL-high gap between frames, in ACLK cycles; legal range 1..255.

Ports:
ACLK  in  1  system clock; all logic on its rising edge.
ARST  in  1  synchronous, active-high reset.
TX_DATA  in  8  byte to send, MSB first.
TX_VALID  in  1  source has a byte on TX_DATA.
TX_READY  out  1  block accepts TX_DATA in this cycle.
TX_BUSY  out  1  frame in progress (any state other than IDLE).
TX_DONE  out  1  one-cycle pulse marking frame end.
SCK  out  1  serial clock; idles low.
SSEL  out  1  active-low slave select; idles high.
MOSI  out  1  serial data.

Behaviour:
- Reset (ARST=1 at an ACLK edge): state IDLE, SCK=0, SSEL=1, MOSI=0, TX_BUSY=0, TX_DONE=0, counters cleared.
  - TX_READY=0 while ARST is high.
  - Reset mid-frame aborts immediately. SSEL rises on the next edge with no hold time; the partial byte is discarded.
- All of SCK, SSEL, MOSI, TX_DONE are registered. TX_READY is combinational from state and is never gated on TX_VALID.
- Handshake: a byte transfers on the edge where TX_VALID & TX_READY. TX_DATA is captured into an 8-bit shift register; later TX_DATA changes are ignored.
- FSM:
  - IDLE: TX_READY=1. On handshake go to SETUP; SSEL<=0, MOSI<=TX_DATA[7].
  - SETUP: hold for CLKDIV cycles, then SCK<=1 and go to SHIFT.
  - SHIFT: SCK toggles every CLKDIV cycles.
    - On each falling edge the shift register shifts left and MOSI<=next bit.
    - MOSI changes only together with SCK falling, so it is stable around every rising edge; the receiver samples on the rising edge.
    - A 3-bit bit counter increments on each falling edge.
    - On the 8th falling edge go to HOLD; MOSI holds the LSB.
  - HOLD: CLKDIV cycles with SCK=0. Then SSEL<=1 and TX_DONE<=1 for one cycle; go to GAP.
  - GAP: IDLE_CYC cycles with SSEL=1, then IDLE.
- Frame timing: SSEL is low for exactly CLKDIV*17 ACLK cycles (setup + 16 half-periods, the last counted as hold). There are exactly 8 SCK rising edges per frame.
- First SSEL-low cycle is the cycle after the handshake. Earliest next handshake is IDLE_CYC+1 cycles after SSEL rises.
- A TX_VALID held high through a frame is not accepted until IDLE.
- The divider counter is 8 bits wide and reloads on every phase change. No wrap-around glitch is permitted on SCK.

Optional Feature:
SND_SPI_TX_BURST_EN
- Defined:
  - TX_READY is also asserted in the cycle of the 8th SCK falling edge.
  - If a handshake occurs there: SSEL stays low, MOSI<=new bit7, HOLD/GAP are skipped, and the FSM re-enters SETUP-length spacing (CLKDIV cycles low) before the next rising edge.
  - TX_DONE pulses once per byte at that edge.
  - Frame ends normally (HOLD, GAP) when no byte is offered there.
- Undefined: every byte is its own SSEL frame, as described above.

Test Plan:
- CLKDIV=4, IDLE_CYC=16, send 0xA5: SSEL low for 68 cycles; 8 SCK rises sampling 1,0,1,0,0,1,0,1; TX_DONE single pulse as SSEL rises; TX_READY back 17 cycles after SSEL rises.
- TX_VALID held high with 0x3C then 0xC3: two separate frames, gap ≥16 cycles, bits 00111100 then 11000011; TX_DATA changed mid-frame does not corrupt the first byte.
- ARST asserted at the 3rd SCK rise of 0xFF: next edge SCK=0, SSEL=1, MOSI=0, TX_BUSY=0, no TX_DONE; a subsequent 0x01 transfers cleanly.
- CLKDIV=4 loopback into the sound parameter SPI receiver, bytes 0x00, 0xFF, 0x5A, 0x81: receiver valid strobe fires once per byte with matching data.
- With SND_SPI_TX_BURST_EN, back-to-back 0x12, 0x34, 0x56: SSEL low continuously, 24 SCK rises, 3 TX_DONE pulses, SSEL high only after the last hold.
